// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared branch-prediction-unit definitions: controller FSM encoding, default
// widths and the mispredict rule used by branch_resolve_ctrl and bpu.
package branch_resolve_ctrl_pkg;

  localparam int BRC_N           = 32;
  localparam int BRC_INDEX_WIDTH = 8;
  localparam int BRC_QDEPTH      = 4;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } brc_state_e;

  // A taken branch must also land on the predicted target to count as correct.
  function automatic logic brc_mispredict(input logic pred_taken,
                                          input logic res_taken,
                                          input logic target_match);
    return (pred_taken != res_taken) || (res_taken && !target_match);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_branch_queue.sv
// In-flight branch FIFO: predictions are pushed at fetch and popped in program
// order as they resolve; clear drops every entry at once on a mispredict.
module branch_queue #(
  parameter int N      = 32,
  parameter int QDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [N-1:0]                push_pc,
  input  logic                        push_taken,
  input  logic [N-1:0]                push_target,
  input  logic                        pop,
  input  logic                        clear,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(QDEPTH):0]     count,
  output logic [N-1:0]                head_pc,
  output logic                        head_taken,
  output logic [N-1:0]                head_target
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  pc_mem     [QDEPTH];
  logic [N-1:0]  target_mem [QDEPTH];
  logic          taken_mem  [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]     <= push_pc;
      target_mem[wr_ptr] <= push_target;
      taken_mem[wr_ptr]  <= push_taken;
    end
  end

  assign head_pc     = pc_mem[rd_ptr];
  assign head_taken  = taken_mem[rd_ptr];
  assign head_target = target_mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: clears the BHT after reset, tracks in-flight
// predictions, writes BHT updates on resolution and flushes fetch on mispredict.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int N           = BRC_N,
  parameter int INDEX_WIDTH = BRC_INDEX_WIDTH,
  parameter int QDEPTH      = BRC_QDEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_pred_valid,
  input  logic [N-1:0]           i_pred_pc,
  input  logic                   i_pred_taken,
  input  logic [N-1:0]           i_pred_target,
  output logic                   o_pred_ready,
  input  logic                   i_res_valid,
  input  logic                   i_res_taken,
  input  logic [N-1:0]           i_res_target,
  output logic                   o_flush,
  output logic [N-1:0]           o_redirect_pc,
  output logic                   o_bht_we,
  output logic                   o_bht_clear,
  output logic [INDEX_WIDTH-1:0] o_bht_index,
  output logic [N-1:0]           o_bht_pc,
  output logic [N-1:0]           o_bht_target,
  output logic                   o_bht_taken,
  output logic                   o_init_busy,
  output logic                   o_orphan,
  output logic [1:0]             o_dbg_state
);

  // Handshake: a prediction is accepted on a rising edge when i_pred_valid and
  // o_pred_ready are both high; o_pred_ready is registered and never depends on
  // i_pred_valid. Resolutions have no backpressure: i_res_valid always refers
  // to the oldest in-flight branch and is consumed the cycle it is presented.

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);

  brc_state_e           state;
  logic [INDEX_WIDTH:0] sweep_idx;
  logic                 q_full;
  logic                 q_empty;
  logic [CW-1:0]        q_count;
  logic [CW-1:0]        count_next;
  logic [N-1:0]         head_pc;
  logic [N-1:0]         head_target;
  logic                 head_taken;
  logic                 active;
  logic                 push;
  logic                 pop;
  logic                 mispredict;

  assign active     = (state != ST_INIT);
  assign push       = i_pred_valid && o_pred_ready;
  assign pop        = active && i_res_valid && !q_empty;
  assign mispredict = pop && brc_mispredict(head_taken, i_res_taken,
                                            head_target == i_res_target);
  assign o_dbg_state = state;

  // A push alongside a mispredicting resolution is younger than the bad branch.
  branch_queue #(
    .N      (N),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (push && !mispredict),
    .push_pc     (i_pred_pc),
    .push_taken  (i_pred_taken),
    .push_target (i_pred_target),
    .pop         (pop),
    .clear       (mispredict),
    .full        (q_full),
    .empty       (q_empty),
    .count       (q_count),
    .head_pc     (head_pc),
    .head_taken  (head_taken),
    .head_target (head_target)
  );

  // Occupancy after this edge, so the registered ready reflects it next cycle.
  always_comb begin
    count_next = q_count;
    if (mispredict) begin
      count_next = '0;
    end else begin
      if (push && !q_full) count_next = count_next + CW'(1);
      if (pop)             count_next = count_next - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      sweep_idx     <= '0;
      o_pred_ready  <= 1'b0;
      o_flush       <= 1'b0;
      o_redirect_pc <= '0;
      o_bht_we      <= 1'b0;
      o_bht_clear   <= 1'b0;
      o_bht_index   <= '0;
      o_bht_pc      <= '0;
      o_bht_target  <= '0;
      o_bht_taken   <= 1'b0;
      o_init_busy   <= 1'b1;
      o_orphan      <= 1'b0;
    end else begin
      o_bht_we <= 1'b0;
      o_flush  <= 1'b0;
      o_orphan <= 1'b0;
      case (state)
        ST_INIT: begin
          // The extra MSB of sweep_idx marks that every index has been cleared.
          if (sweep_idx[INDEX_WIDTH]) begin
            state        <= ST_RUN;
            sweep_idx    <= '0;
            o_bht_clear  <= 1'b0;
            o_init_busy  <= 1'b0;
            o_pred_ready <= 1'b1;
          end else begin
            o_bht_we     <= 1'b1;
            o_bht_clear  <= 1'b1;
            o_bht_index  <= sweep_idx[INDEX_WIDTH-1:0];
            o_bht_pc     <= '0;
            o_bht_target <= '0;
            o_bht_taken  <= 1'b0;
            sweep_idx    <= sweep_idx + 1'b1;
          end
        end
        default: begin
          o_bht_clear <= 1'b0;
          if (pop) begin
            o_bht_we     <= 1'b1;
            o_bht_index  <= head_pc[INDEX_WIDTH-1:0];
            o_bht_pc     <= head_pc;
            o_bht_target <= i_res_target;
            o_bht_taken  <= i_res_taken;
          end else if (i_res_valid) begin
            o_orphan <= 1'b1;
          end
          if (mispredict) begin
            o_flush       <= 1'b1;
            o_redirect_pc <= i_res_taken ? i_res_target : head_pc + N'(4);
            state         <= ST_RECOVER;
            o_pred_ready  <= 1'b0;
          end else begin
            state         <= ST_RUN;
            o_pred_ready  <= (count_next != Q_FULL);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: a reference model of the
// in-flight queue feeds an expected-response scoreboard checked by a monitor.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  localparam int N     = 32;
  localparam int IW    = 8;
  localparam int QD    = 4;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_pred_valid = 1'b0;
  logic [N-1:0]  i_pred_pc = '0;
  logic          i_pred_taken = 1'b0;
  logic [N-1:0]  i_pred_target = '0;
  logic          i_res_valid = 1'b0;
  logic          i_res_taken = 1'b0;
  logic [N-1:0]  i_res_target = '0;
  logic          o_pred_ready;
  logic          o_flush;
  logic [N-1:0]  o_redirect_pc;
  logic          o_bht_we;
  logic          o_bht_clear;
  logic [IW-1:0] o_bht_index;
  logic [N-1:0]  o_bht_pc;
  logic [N-1:0]  o_bht_target;
  logic          o_bht_taken;
  logic          o_init_busy;
  logic          o_orphan;
  logic [1:0]    o_dbg_state;

  branch_resolve_ctrl #(.N(N), .INDEX_WIDTH(IW), .QDEPTH(QD)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pred_valid  (i_pred_valid),
    .i_pred_pc     (i_pred_pc),
    .i_pred_taken  (i_pred_taken),
    .i_pred_target (i_pred_target),
    .o_pred_ready  (o_pred_ready),
    .i_res_valid   (i_res_valid),
    .i_res_taken   (i_res_taken),
    .i_res_target  (i_res_target),
    .o_flush       (o_flush),
    .o_redirect_pc (o_redirect_pc),
    .o_bht_we      (o_bht_we),
    .o_bht_clear   (o_bht_clear),
    .o_bht_index   (o_bht_index),
    .o_bht_pc      (o_bht_pc),
    .o_bht_target  (o_bht_target),
    .o_bht_taken   (o_bht_taken),
    .o_init_busy   (o_init_busy),
    .o_orphan      (o_orphan),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ---------------- model and scoreboard state ----------------
  typedef struct packed {
    logic          orphan;
    logic          flush;
    logic [N-1:0]  redirect;
    logic [IW-1:0] idx;
    logic [N-1:0]  pc;
    logic [N-1:0]  target;
    logic          taken;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  typedef struct {
    logic [N-1:0] pc;
    logic         taken;
    logic [N-1:0] target;
  } br_t;

  logic [EXP_W-1:0] exp_q[$];
  int               due_q[$];
  br_t              m_q[$];
  bit               m_recover = 1'b0;
  int               tests_run = 0;
  int               tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({o_flush, o_orphan, o_bht_we, o_bht_clear, o_bht_taken,
                              o_pred_ready, o_init_busy}), 64'(7'b0000001));
    check({tag, "_redirect"}, 64'(o_redirect_pc), 64'(0));
    check({tag, "_bht_pc"}, 64'(o_bht_pc), 64'(0));
    check({tag, "_bht_tgt"}, 64'(o_bht_target), 64'(0));
    check({tag, "_bht_idx"}, 64'(o_bht_index), 64'(0));
    check({tag, "_state"}, 64'(o_dbg_state), 64'(ST_INIT));
  endtask

  // Checks the clear sweep for its first n indices while injecting traffic
  // that must be ignored; returns at the negedge showing index n-1.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("sweep_idx", 64'(o_bht_index), 64'(i));
      check("sweep_ctl", 64'({o_bht_we, o_bht_clear, o_init_busy, o_pred_ready}), 64'(4'b1110));
      i_res_valid  = (i < n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_pred_valid = (i < n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_pred_pc    = N'($urandom);
    end
    i_res_valid  = 1'b0;
    i_pred_valid = 1'b0;
  endtask

  task automatic check_post_sweep();
    @(negedge clk);
    check("post_sweep_ctl", 64'({o_bht_we, o_bht_clear, o_init_busy, o_pred_ready}), 64'(4'b0001));
    check("post_sweep_state", 64'(o_dbg_state), 64'(ST_RUN));
    m_q.delete();
    m_recover = 1'b0;
  endtask

  // One cycle of traffic: the model decides the response, then inputs are driven.
  task automatic step(input logic pv, input logic [N-1:0] ppc, input logic pt,
                      input logic [N-1:0] ptgt, input logic rv, input logic rt,
                      input logic [N-1:0] rtgt);
    bit   model_ready;
    bit   mis;
    br_t  h;
    exp_t e;
    @(negedge clk);
    model_ready = !m_recover && (m_q.size() < QD);
    check("pred_ready", 64'(o_pred_ready), 64'(model_ready));
    m_recover = 1'b0;
    mis = 1'b0;
    if (rv) begin
      e = '0;
      if (m_q.size() == 0) begin
        e.orphan = 1'b1;
      end else begin
        h = m_q.pop_front();
        mis = (h.taken != rt) || (rt && (h.target != rtgt));
        e.flush    = mis;
        e.redirect = rt ? rtgt : N'(h.pc + 4);
        e.idx      = IW'(h.pc % DEPTH);
        e.pc       = h.pc;
        e.target   = rtgt;
        e.taken    = rt;
        if (mis) begin
          m_q.delete();
          m_recover = 1'b1;
        end
      end
      exp_q.push_back(e);
      due_q.push_back(cycle_cnt + 1);
    end
    if (pv && model_ready && !mis) m_q.push_back('{ppc, pt, ptgt});
    i_pred_valid  = pv;
    i_pred_pc     = ppc;
    i_pred_taken  = pt;
    i_pred_target = ptgt;
    i_res_valid   = rv;
    i_res_taken   = rt;
    i_res_target  = rtgt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [N-1:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    return N'($urandom_range(0, 32'h3FFF)) << 2;
  endfunction

  function automatic logic [N-1:0] rand_tgt();
    return N'(32'h1000 + 16 * $urandom_range(0, 3));
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    int   due;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (o_orphan || o_flush || (o_bht_we && !o_bht_clear))) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_output: orphan=%0b flush=%0b we=%0b pc=0x%0h with nothing expected",
                   o_orphan, o_flush, o_bht_we, o_bht_pc);
        end else begin
          e   = exp_t'(exp_q.pop_front());
          due = due_q.pop_front();
          check("latency", 64'(cycle_cnt), 64'(due));
          check("orphan", 64'(o_orphan), 64'(e.orphan));
          check("flush", 64'(o_flush), 64'(e.flush));
          check("bht_we", 64'(o_bht_we && !o_bht_clear), 64'(!e.orphan));
          if (!e.orphan) begin
            check("bht_idx", 64'(o_bht_index), 64'(e.idx));
            check("bht_pc", 64'(o_bht_pc), 64'(e.pc));
            check("bht_tgt", 64'(o_bht_target), 64'(e.target));
            check("bht_taken", 64'(o_bht_taken), 64'(e.taken));
            if (e.flush) check("redirect_pc", 64'(o_redirect_pc), 64'(e.redirect));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    sweep(DEPTH);
    check_post_sweep();

    // Correct taken prediction, then two mispredict flavours.
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h200);
    idle(2);
    step(1'b1, 32'h104, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h300);
    step(1'b1, 32'h150, 1'b1, 32'h1000, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle(1);
    step(1'b1, 32'h108, 1'b1, 32'h400, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);

    // Fill to capacity, drop a push, then push+resolve with three queued.
    for (int i = 0; i < 5; i++) step(1'b1, N'(32'h200 + 4 * i), 1'b1, 32'h1000, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h1000);
    step(1'b1, 32'h220, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h1000);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h1000);
    idle(2);

    // Pc wrap on the fall-through redirect.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1000, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 99) < 60), rand_pc(), 1'($urandom_range(0, 1)), rand_tgt(),
           1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)), rand_tgt());
    for (int i = 0; i < 3; i++) step(1'b1, rand_pc(), 1'b0, rand_tgt(), 1'b0, 1'b0, '0);
    idle(2);

    // Reset mid-run with entries in flight, then mid-sweep at index 0x80.
    rst = 1'b1;
    m_q.delete();
    m_recover = 1'b0;
    #1;
    check_reset_outputs("reset_run");
    @(negedge clk);
    rst = 1'b0;
    sweep(9'h81);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_sweep");
    @(negedge clk);
    rst = 1'b0;
    sweep(DEPTH);
    check_post_sweep();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h1000);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), rand_tgt(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_tgt());
    idle(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
